// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV64 back-end pipeline: control bundle, pipeline
// register layouts, forwarding selects and the data-memory handshake states.
package rv_pipe_pkg;

  localparam int PIPE_XLEN   = 64;
  localparam int PIPE_REG_AW = 5;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
  } ctrl_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_t;

  typedef struct packed {
    ctrl_t                  ctrl;
    logic                   zero;
    logic [PIPE_XLEN-1:0]   alu;
    logic [PIPE_XLEN-1:0]   store_data;
    logic [PIPE_XLEN-1:0]   br_target;
    logic [PIPE_REG_AW-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic                   regwrite;
    logic                   memtoreg;
    logic [PIPE_REG_AW-1:0] rd;
    logic [PIPE_XLEN-1:0]   alu;
    logic [PIPE_XLEN-1:0]   load_data;
  } mem_wb_t;

endpackage

// File: rtl/forwarding_unit.sv
// Picks the operand source for one EX source register: EX/MEM result,
// MEM/WB result, or the register file.
module forwarding_unit
  import rv_pipe_pkg::*;
#(
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic              exm_regwrite,
  input  logic              exm_memread,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [REG_AW-1:0] rs,
  output fwd_sel_t          sel
);

  // A load sitting in EX/MEM has no data yet; load-use is stalled up front.
  always_comb begin
    sel = FWD_RF;
    if (exm_regwrite && !exm_memread && exm_rd != '0 && exm_rd == rs)
      sel = FWD_MEM;
    else if (wb_regwrite && wb_rd != '0 && wb_rd == rs)
      sel = FWD_WB;
  end

endmodule

// File: rtl/mem_wb_backend.sv
// Back half of the RV64 pipeline: EX/MEM and MEM/WB registers, data-memory
// handshake with timeout, branch redirect and forwarding selects.
module mem_wb_backend
  import rv_pipe_pkg::*;
#(
  parameter int XLEN        = PIPE_XLEN,
  parameter int REG_AW      = PIPE_REG_AW,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   ex_alu,
  input  logic              ex_zero,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [XLEN-1:0]   ex_br_target,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [4:0]        ex_ctrl,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              flush,
  output logic [XLEN-1:0]   pc_target,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic [XLEN-1:0]   ex_mem_alu,
  output logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_we,
  output logic              dmem_err
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  ex_mem_t          exm;
  mem_wb_t          mwb;
  mem_state_t       state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_op, mem_ack, timeout;
  fwd_sel_t         fwd_a, fwd_b;

  assign mem_op  = exm.ctrl.memread | exm.ctrl.memwrite;
  assign mem_ack = mem_op & dmem_ack;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_op && !dmem_ack) state_next = WAIT;
      WAIT:    if (dmem_ack || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The abort cycle releases stall so the dead op leaves EX/MEM as a bubble.
  always_comb begin
    timeout  = (state == WAIT) && !dmem_ack && (wait_cnt == CNT_LAST);
    dmem_req = mem_op;
    stall    = mem_op && !dmem_ack && !timeout;
  end

  always_ff @(posedge clk) begin
    if (reset)                                  wait_cnt <= '0;
    else if (state == WAIT && state_next == WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                                        wait_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset)        dmem_err <= 1'b0;
    else if (timeout) dmem_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exm <= '0;
    end else if (!stall) begin
      exm.ctrl       <= flush ? ctrl_t'('0) : ctrl_t'(ex_ctrl);
      exm.zero       <= ex_zero;
      exm.alu        <= ex_alu;
      exm.store_data <= ex_store_data;
      exm.br_target  <= ex_br_target;
      exm.rd         <= ex_rd;
    end
  end

  // Stalled or aborted memory ops hand MEM/WB a bubble so nothing writes twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      mwb <= '0;
    end else begin
      if (!mem_op || mem_ack) begin
        mwb.regwrite <= exm.ctrl.regwrite;
        mwb.memtoreg <= exm.ctrl.memtoreg;
        mwb.rd       <= exm.rd;
        mwb.alu      <= exm.alu;
      end else begin
        mwb.regwrite <= 1'b0;
        mwb.memtoreg <= 1'b0;
      end
      if (mem_ack) mwb.load_data <= dmem_rdata;
    end
  end

  assign flush      = exm.ctrl.branch & exm.zero;
  assign pc_target  = exm.br_target;
  assign dmem_we    = exm.ctrl.memwrite;
  assign dmem_addr  = exm.alu;
  assign dmem_wdata = exm.store_data;
  assign ex_mem_alu = exm.alu;
  assign wb_data    = mwb.memtoreg ? mwb.load_data : mwb.alu;
  assign wb_rd      = mwb.rd;
  assign wb_we      = mwb.regwrite && (mwb.rd != '0);
  assign forward_a  = fwd_a;
  assign forward_b  = fwd_b;

  forwarding_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .exm_regwrite (exm.ctrl.regwrite),
    .exm_memread  (exm.ctrl.memread),
    .exm_rd       (exm.rd),
    .wb_regwrite  (mwb.regwrite),
    .wb_rd        (mwb.rd),
    .rs           (ex_rs1),
    .sel          (fwd_a)
  );

  forwarding_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .exm_regwrite (exm.ctrl.regwrite),
    .exm_memread  (exm.ctrl.memread),
    .exm_rd       (exm.rd),
    .wb_regwrite  (mwb.regwrite),
    .wb_rd        (mwb.rd),
    .rs           (ex_rs2),
    .sel          (fwd_b)
  );

endmodule

// File: tb/tb_mem_wb_backend.sv
// Self-checking bench for mem_wb_backend: directed pipeline scenarios plus a
// randomized ALU/load stream checked against an instruction-level model.
module tb_mem_wb_backend;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ex_alu, ex_store_data, ex_br_target, dmem_addr, dmem_wdata, dmem_rdata;
  logic [63:0] pc_target, ex_mem_alu, wb_data;
  logic        ex_zero, dmem_req, dmem_we, dmem_ack, stall, flush, wb_we, dmem_err;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2, ex_ctrl, wb_rd;
  logic [1:0]  forward_a, forward_b;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        rw;
    logic        mr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] alu;
    logic [63:0] ldata;
  } op_t;

  mem_wb_backend #(.XLEN(64), .REG_AW(5), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ex_alu(ex_alu), .ex_zero(ex_zero),
    .ex_store_data(ex_store_data), .ex_br_target(ex_br_target), .ex_rd(ex_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_ctrl(ex_ctrl), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall), .flush(flush),
    .pc_target(pc_target), .forward_a(forward_a), .forward_b(forward_b),
    .ex_mem_alu(ex_mem_alu), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .dmem_err(dmem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] ctrl, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [63:0] alu, input logic zero,
                       input logic [63:0] sd, input logic [63:0] tgt);
    ex_ctrl = ctrl; ex_rd = rd; ex_rs1 = rs1; ex_rs2 = rs2;
    ex_alu = alu; ex_zero = zero; ex_store_data = sd; ex_br_target = tgt;
  endtask

  task automatic bubble();
    drive(5'b0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    bubble();
    tick(); tick();
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b exp=0", dmem_req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (wb_we !== 1'b0 || wb_data !== 64'd0) begin failures++; $display("[TB] FAIL reset_wb got we=%b data=%h exp 0/0", wb_we, wb_data); end
    checks++; if (dmem_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", dmem_err); end
    checks++; if (forward_a !== 2'b00) begin failures++; $display("[TB] FAIL reset_fwd got=%b exp=00", forward_a); end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b;
    a = 64'h1111_2222_3333_4444; b = 64'h0000_0000_0000_0055;
    drive(5'b00001, 5'd5, 5'd1, 5'd2, a, 1'b0, 64'd0, 64'd0);
    tick();
    drive(5'b00001, 5'd6, 5'd5, 5'd3, b, 1'b0, 64'd0, 64'd0);
    #1;
    checks++; if (forward_a !== 2'b10) begin failures++; $display("[TB] FAIL b2b_fwd_a got=%b exp=10", forward_a); end
    checks++; if (ex_mem_alu !== a) begin failures++; $display("[TB] FAIL b2b_exm_alu got=%h exp=%h", ex_mem_alu, a); end
    tick();
    drive(5'b0, 5'd0, 5'd6, 5'd5, 64'd0, 1'b0, 64'd0, 64'd0);
    #1;
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== a) begin failures++; $display("[TB] FAIL b2b_wb got we=%b rd=%0d data=%h exp 1/5/%h", wb_we, wb_rd, wb_data, a); end
    checks++; if (forward_a !== 2'b10) begin failures++; $display("[TB] FAIL b2b_fwd_a2 got=%b exp=10", forward_a); end
    checks++; if (forward_b !== 2'b01) begin failures++; $display("[TB] FAIL b2b_fwd_b got=%b exp=01", forward_b); end
    tick();
    bubble();
  endtask

  task automatic test_x0();
    drive(5'b00001, 5'd0, 5'd0, 5'd0, 64'hABCD, 1'b0, 64'd0, 64'd0);
    tick();
    drive(5'b0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0);
    #1;
    checks++; if (forward_a !== 2'b00) begin failures++; $display("[TB] FAIL x0_fwd got=%b exp=00", forward_a); end
    tick(); #1;
    checks++; if (wb_we !== 1'b0) begin failures++; $display("[TB] FAIL x0_we got=%b exp=0", wb_we); end
  endtask

  task automatic test_load_delay();
    logic [63:0] c;
    c = 64'h0123_4567_89AB_CDEF;
    bubble(); tick();
    drive(5'b01011, 5'd7, 5'd0, 5'd0, 64'h80, 1'b0, 64'd0, 64'd0);
    tick();
    drive(5'b00001, 5'd9, 5'd0, 5'd0, c, 1'b0, 64'd0, 64'd0);
    for (int i = 1; i <= 4; i++) begin
      dmem_ack = (i == 4); dmem_rdata = (i == 4) ? 64'hDEAD_BEEF : 64'h5A5A;
      #1;
      checks++; if (stall !== (i != 4)) begin failures++; $display("[TB] FAIL ld_stall c%0d got=%b exp=%b", i, stall, (i != 4)); end
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 64'h80) begin failures++; $display("[TB] FAIL ld_req c%0d got req=%b we=%b addr=%h exp 1/0/80", i, dmem_req, dmem_we, dmem_addr); end
      checks++; if (wb_we !== 1'b0) begin failures++; $display("[TB] FAIL ld_bubble_we c%0d got=%b exp=0", i, wb_we); end
      tick();
    end
    dmem_ack = 1'b0; dmem_rdata = 64'hFFFF_0000_FFFF_0000;
    drive(5'b0, 5'd0, 5'd9, 5'd7, 64'd0, 1'b0, 64'd0, 64'd0);
    #1;
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 64'hDEAD_BEEF) begin failures++; $display("[TB] FAIL ld_wb got we=%b rd=%0d data=%h exp 1/7/deadbeef", wb_we, wb_rd, wb_data); end
    checks++; if (forward_a !== 2'b10 || forward_b !== 2'b01) begin failures++; $display("[TB] FAIL ld_fwd got a=%b b=%b exp 10/01", forward_a, forward_b); end
    tick();
    bubble(); #1;
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd9 || wb_data !== c) begin failures++; $display("[TB] FAIL ld_next_wb got we=%b rd=%0d data=%h exp 1/9/%h", wb_we, wb_rd, wb_data, c); end
    tick(); #1;
    checks++; if (wb_we !== 1'b0) begin failures++; $display("[TB] FAIL ld_tail_we got=%b exp=0", wb_we); end
  endtask

  task automatic test_store_zero_wait();
    bubble(); tick();
    drive(5'b00100, 5'd0, 5'd0, 5'd0, 64'h200, 1'b0, 64'hCAFE_F00D, 64'd0);
    tick();
    bubble(); dmem_ack = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL st_stall got=%b exp=0", stall); end
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 64'h200 || dmem_wdata !== 64'hCAFE_F00D) begin failures++; $display("[TB] FAIL st_req got req=%b we=%b addr=%h wdata=%h exp 1/1/200/cafef00d", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    tick();
    dmem_ack = 1'b0; #1;
    checks++; if (wb_we !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("[TB] FAIL st_after got we=%b stall=%b req=%b exp 0/0/0", wb_we, stall, dmem_req); end
  endtask

  task automatic test_branch();
    bubble(); tick();
    drive(5'b10000, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 64'd0, 64'h300);
    tick();
    bubble(); #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL br_not_taken got=%b exp=0", flush); end
    drive(5'b10000, 5'd0, 5'd0, 5'd0, 64'd0, 1'b1, 64'd0, 64'h100);
    tick();
    drive(5'b01011, 5'd3, 5'd0, 5'd0, 64'h40, 1'b0, 64'd0, 64'd0);
    #1;
    checks++; if (flush !== 1'b1 || pc_target !== 64'h100 || stall !== 1'b0) begin failures++; $display("[TB] FAIL br_flush got flush=%b tgt=%h stall=%b exp 1/100/0", flush, pc_target, stall); end
    tick();
    bubble(); #1;
    checks++; if (flush !== 1'b0 || dmem_req !== 1'b0 || wb_we !== 1'b0) begin failures++; $display("[TB] FAIL br_bubble got flush=%b req=%b we=%b exp 0/0/0", flush, dmem_req, wb_we); end
    tick(); #1;
    checks++; if (wb_we !== 1'b0) begin failures++; $display("[TB] FAIL br_bubble_wb got=%b exp=0", wb_we); end
  endtask

  task automatic test_timeout();
    int n;
    bubble(); dmem_ack = 1'b0; tick();
    drive(5'b01011, 5'd4, 5'd0, 5'd0, 64'h400, 1'b0, 64'd0, 64'd0);
    tick();
    bubble(); #1;
    n = 0;
    while (stall && n < 40) begin
      n++;
      if (wb_we !== 1'b0 || dmem_err !== 1'b0) begin
        checks++; failures++;
        $display("[TB] FAIL to_wait c%0d got we=%b err=%b exp 0/0", n, wb_we, dmem_err);
      end
      tick();
    end
    checks++; if (n !== TO) begin failures++; $display("[TB] FAIL to_stall_cycles got=%0d exp=%0d", n, TO); end
    tick();
    checks++; if (dmem_err !== 1'b1 || dmem_req !== 1'b0 || stall !== 1'b0 || wb_we !== 1'b0) begin failures++; $display("[TB] FAIL to_abort got err=%b req=%b stall=%b we=%b exp 1/0/0/0", dmem_err, dmem_req, stall, wb_we); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (dmem_err !== 1'b1 || wb_we !== 1'b0) begin failures++; $display("[TB] FAIL to_sticky got err=%b we=%b exp 1/0", dmem_err, wb_we); end
    drive(5'b01011, 5'd4, 5'd0, 5'd0, 64'h400, 1'b0, 64'd0, 64'd0);
    tick();
    bubble(); tick(); tick();
    checks++; if (stall !== 1'b1 || dmem_req !== 1'b1) begin failures++; $display("[TB] FAIL to_rewait got stall=%b req=%b exp 1/1", stall, dmem_req); end
    reset = 1'b1;
    tick();
    checks++; if (dmem_req !== 1'b0 || dmem_err !== 1'b0 || stall !== 1'b0) begin failures++; $display("[TB] FAIL to_reset got req=%b err=%b stall=%b exp 0/0/0", dmem_req, dmem_err, stall); end
    reset = 1'b0;
    tick(); #1;
    checks++; if (wb_we !== 1'b0) begin failures++; $display("[TB] FAIL to_reset_wb got=%b exp=0", wb_we); end
  endtask

  function automatic logic [1:0] ref_fwd(op_t exm, op_t mwb, logic [4:0] rs);
    if (exm.rw && !exm.mr && exm.rd != 0 && exm.rd == rs) return 2'b10;
    if (mwb.rw && mwb.rd != 0 && mwb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Instruction-level model: op k sits in EX/MEM during cycle k+1 and in MEM/WB during k+2.
  task automatic test_random();
    localparam int RN = 200;
    op_t h[RN];
    op_t exm, mwb, nop;
    logic [1:0] ea, eb;
    logic [63:0] ed;
    nop = '0;
    bubble(); dmem_ack = 1'b0; tick(); tick();
    for (int c = 0; c < RN; c++) begin
      h[c].mr    = ($urandom_range(0, 3) == 0);
      h[c].rw    = h[c].mr ? 1'b1 : 1'($urandom_range(0, 1));
      h[c].rd    = 5'($urandom_range(0, 7));
      h[c].rs1   = 5'($urandom_range(0, 7));
      h[c].rs2   = 5'($urandom_range(0, 7));
      h[c].alu   = {$urandom, $urandom};
      h[c].ldata = '0;
      drive({1'b0, h[c].mr, 1'b0, h[c].mr, h[c].rw}, h[c].rd, h[c].rs1, h[c].rs2,
            h[c].alu, 1'b0, 64'd0, 64'd0);
      if (c >= 1 && h[c-1].mr) begin
        dmem_ack = 1'b1; dmem_rdata = {$urandom, $urandom}; h[c-1].ldata = dmem_rdata;
      end else begin
        dmem_ack = 1'b0; dmem_rdata = {$urandom, $urandom};
      end
      exm = (c >= 1) ? h[c-1] : nop;
      mwb = (c >= 2) ? h[c-2] : nop;
      ea = ref_fwd(exm, mwb, h[c].rs1);
      eb = ref_fwd(exm, mwb, h[c].rs2);
      ed = mwb.mr ? mwb.ldata : mwb.alu;
      #1;
      checks++; if (forward_a !== ea || forward_b !== eb) begin failures++; $display("[TB] FAIL rnd_fwd c%0d got a=%b b=%b exp %b/%b", c, forward_a, forward_b, ea, eb); end
      checks++; if (wb_we !== (mwb.rw && mwb.rd != 0) || stall !== 1'b0) begin failures++; $display("[TB] FAIL rnd_we c%0d got we=%b stall=%b exp %b/0", c, wb_we, stall, (mwb.rw && mwb.rd != 0)); end
      if (mwb.rw && mwb.rd != 0) begin
        checks++; if (wb_rd !== mwb.rd || wb_data !== ed) begin failures++; $display("[TB] FAIL rnd_wb c%0d got rd=%0d data=%h exp %0d/%h", c, wb_rd, wb_data, mwb.rd, ed); end
      end
      tick();
    end
    bubble(); dmem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_x0();
    test_load_delay();
    test_store_zero_wait();
    test_branch();
    test_timeout();
    test_random();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
